// File: rtl/d_ff.sv
`default_nettype none
// ============================================================================
//  Module   : d_ff
//  Purpose  : WIDTH-bit rising-edge D register with synchronous active-low
//             reset that loads RESET_VALUE.
//  Revision : 1.0  initial release
// ============================================================================
module d_ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Reset is only looked at on the clock edge, so pulses between edges are invisible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: tb/tb_d_ff.sv
`default_nettype none
// ============================================================================
//  Module   : tb_d_ff
//  Purpose  : Self-checking bench for d_ff (1-bit default and 8-bit A5 build).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_d_ff;

    localparam logic [7:0] c_RV8 = 8'hA5;

    logic       clk = 1'b0;
    logic       rst1, rst8;
    logic       d1, q1;
    logic [7:0] d8, q8;

    int passed = 0;
    int total  = 0;

    // Reference model: each queued entry is the value q must show after the next edge.
    logic       exp1[$];
    logic [7:0] exp8[$];

    d_ff dut1 (
        .clk   (clk),
        .reset (rst1),
        .d     (d1),
        .q     (q1)
    );

    d_ff #(.WIDTH(8), .RESET_VALUE(c_RV8)) dut8 (
        .clk   (clk),
        .reset (rst8),
        .d     (d8),
        .q     (q8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst1 = 1'b0; d1 = 1'b1;
        rst8 = 1'b0; d8 = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (q1 !== 1'b0) $display("FAIL reset_hold1[%0d] q=%b expected 0", i, q1);
            else passed++;
            total++;
            if (q8 !== c_RV8) $display("FAIL reset_hold8[%0d] q=%h expected %h", i, q8, c_RV8);
            else passed++;
        end
        rst1 = 1'b1; d1 = 1'b1;
        rst8 = 1'b1; d8 = 8'h3C;
        tick();
        total++;
        if (q1 !== 1'b1) $display("FAIL reset_release1 q=%b expected 1", q1);
        else passed++;
        total++;
        if (q8 !== 8'h3C) $display("FAIL reset_release8 q=%h expected 3c", q8);
        else passed++;
    endtask

    task automatic test_capture();
        logic [7:0] pat;
        pat = 8'b1100_1100;
        rst1 = 1'b1;
        d1 = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            d1 = pat[7-i];
            tick();
            total++;
            if (q1 !== pat[7-i]) $display("FAIL capture[%0d] q=%b expected %b", i, q1, pat[7-i]);
            else passed++;
        end
    endtask

    task automatic test_feedback();
        logic held;
        logic muxData;
        rst1 = 1'b1;
        d1 = 1'b1;
        tick();
        held = 1'b1;
        muxData = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) muxData = ~muxData;
            d1 = q1;                       // select=0: loop q back into d
            tick();
            total++;
            if (q1 !== held) $display("FAIL feedback_hold[%0d] q=%b expected %b", i, q1, held);
            else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            muxData = i[0];                // select=1: track mux data
            d1 = muxData;
            tick();
            total++;
            if (q1 !== muxData) $display("FAIL feedback_track[%0d] q=%b expected %b", i, q1, muxData);
            else passed++;
        end
    endtask

    task automatic test_async_pulse();
        rst1 = 1'b1; d1 = 1'b1;
        rst8 = 1'b1; d8 = 8'h5A;
        tick();
        #1 rst1 = 1'b0; rst8 = 1'b0;
        #1;
        total++;
        if (q1 !== 1'b1) $display("FAIL async_mid1 q=%b expected 1", q1);
        else passed++;
        total++;
        if (q8 !== 8'h5A) $display("FAIL async_mid8 q=%h expected 5a", q8);
        else passed++;
        #1 rst1 = 1'b1; rst8 = 1'b1;
        tick();
        total++;
        if (q1 !== 1'b1) $display("FAIL async_after1 q=%b expected 1", q1);
        else passed++;
        total++;
        if (q8 !== 8'h5A) $display("FAIL async_after8 q=%h expected 5a", q8);
        else passed++;
    endtask

    task automatic test_glitch();
        rst1 = 1'b1; d1 = 1'b0;
        tick();
        #1 d1 = 1'b1;
        #1;
        total++;
        if (q1 !== 1'b0) $display("FAIL glitch_transparent q=%b expected 0", q1);
        else passed++;
        #1 d1 = 1'b0;
        tick();
        total++;
        if (q1 !== 1'b0) $display("FAIL glitch_edge q=%b expected 0", q1);
        else passed++;
    endtask

    task automatic test_random();
        logic       prev1, e1;
        logic [7:0] prev8, e8;
        prev1 = q1;
        prev8 = q8;
        for (int i = 0; i < 300; i++) begin
            rst1 = ($urandom_range(0, 6) != 0);
            rst8 = ($urandom_range(0, 6) != 0);
            d1   = 1'($urandom);
            d8   = 8'($urandom);
            exp1.push_back(rst1 ? d1 : 1'b0);
            exp8.push_back(rst8 ? d8 : c_RV8);
            #2;
            total++;
            if (q1 !== prev1) $display("FAIL rand_hold1[%0d] q=%b expected %b", i, q1, prev1);
            else passed++;
            total++;
            if (q8 !== prev8) $display("FAIL rand_hold8[%0d] q=%h expected %h", i, q8, prev8);
            else passed++;
            tick();
            e1 = exp1.pop_front();
            e8 = exp8.pop_front();
            total++;
            if (q1 !== e1) $display("FAIL rand_q1[%0d] q=%b expected %b", i, q1, e1);
            else passed++;
            total++;
            if (q8 !== e8) $display("FAIL rand_q8[%0d] q=%h expected %h", i, q8, e8);
            else passed++;
            prev1 = e1;
            prev8 = e8;
        end
    endtask

    initial begin
        rst1 = 1'b0; rst8 = 1'b0;
        d1 = 1'b0;   d8 = 8'h00;
        #1;
        test_reset();
        test_capture();
        test_feedback();
        test_async_pulse();
        test_glitch();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/d_ff.md
D_FF -- requirements
Module: d_ff

Interface
REQ-001 Parameter: WIDTH, default 1, data width in bits of d and q; legal range 1..64.
REQ-002 Parameter: RESET_VALUE, default all-zeros (WIDTH bits), value loaded into q during reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge only.
REQ-004 reset  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
REQ-005 d  input  WIDTH  data to capture.
REQ-006 q  output  WIDTH  registered data; driven directly from the storage element, no combinational path from d or reset.

Function
REQ-007 On each rising clk edge with reset=1, q SHALL take the value of d sampled at that edge.
REQ-008 Latency d->q SHALL be exactly one clock edge; no bypass, no transparency while clk is high or low.
REQ-009 Between rising edges q SHALL hold its value regardless of changes on d or reset.
REQ-010 All WIDTH bits SHALL be captured in the same edge; bits are independent, no arithmetic or width conversion.
REQ-011 No enable input; holding is achieved externally by feeding q back to d, and the block SHALL support such a feedback loop with no hold hazard (q updates after the edge, never in the same delta as sampling).
REQ-012 d changing in the same timestep as the clock edge via nonblocking assignment SHALL be sampled as its pre-edge value.
REQ-013 X/Z on d SHALL propagate to q on the next edge; no masking.

Reset
REQ-014 On a rising clk edge with reset=0, q SHALL become RESET_VALUE, overriding d.
REQ-015 Reset is not asynchronous: asserting reset=0 between edges SHALL not change q until the next rising edge.
REQ-016 Deasserting reset (0->1) SHALL make the first capture of d occur on the first rising edge at which reset=1 is sampled.
REQ-017 Reset asserted mid-stream SHALL take effect on its first sampled edge regardless of d; q SHALL remain RESET_VALUE for every edge while reset=0.
REQ-018 Before the first rising edge q is undefined (X); no power-on initial value is required.

Verification
REQ-019 Reset: reset=0, d=1 for 2 edges -> q=0 after first edge, stays 0; release reset=1, d=1 -> q=1 after next edge.
REQ-020 Capture sequence: reset=1, d held 0,1,0,1 for two edges each -> q follows 0,0,1,1,0,0,1,1, each one edge late.
REQ-021 Hold via feedback: d driven from q through an external mux with select=0 and mux data toggling 0/1 every two edges -> q constant at last captured value across 8 edges; select=1 resumes tracking with one-edge latency.
REQ-022 Async check: with q=1, pulse reset=0 for less than half a clock period between edges and return it to 1 before the next edge -> q stays 1.
REQ-023 Glitch on d: toggle d 0->1->0 between edges with d=0 at the edge -> q=0; no intermediate change.
REQ-024 Width: WIDTH=8, RESET_VALUE=8'hA5; reset=0 -> q=8'hA5; reset=1, d=8'h3C -> q=8'h3C after one edge.
